// File: rtl/led_frame_buffer_pkg.sv
// Shared definitions for the LED frame buffer slice.
//  - default panel geometry (columns, rows, bits per colour channel)
//  - write-side FSM state encoding
//  - pixel field helpers for the 4-bit-per-channel default packing {R,G,B}
package led_frame_buffer_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_HEIGHT = 32;
   localparam int DEF_BPC    = 4;
   localparam int CHANNELS   = 3;

   typedef enum logic [1:0] {
      WAIT_SOF  = 2'd0,
      FILL      = 2'd1,
      PEND_SWAP = 2'd2
   } wr_state_t;

   // Field extraction for the default BPC=4 pixel word {R[3:0],G[3:0],B[3:0]}.
   function automatic logic [3:0] pix_r(input logic [11:0] pix);
      return pix[11:8];
   endfunction

   function automatic logic [3:0] pix_g(input logic [11:0] pix);
      return pix[7:4];
   endfunction

   function automatic logic [3:0] pix_b(input logic [11:0] pix);
      return pix[3:0];
   endfunction

endpackage

// File: rtl/led_frame_buffer_if.sv
// Bus bundle between the pixel source / HUB75 driver side (master) and the
// frame buffer (slave).
//  Pixel stream : PIX_DATA, PIX_VALID, PIX_SOF -> ; <- PIX_READY
//  Scan reads   : RD_EN, RD_COL, RD_ROW -> ; <- RD_TOP, RD_BOT, RD_VALID
//  Frame control: FRAME_END -> ; <- FRAME_SWAP, SYNC_ERR
interface led_frame_buffer_if
   import led_frame_buffer_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int HEIGHT = DEF_HEIGHT,
   parameter int BPC    = DEF_BPC
);
   localparam int PW = CHANNELS * BPC;
   localparam int XW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT / 2);

   logic [PW-1:0] PIX_DATA;
   logic          PIX_VALID;
   logic          PIX_SOF;
   logic          PIX_READY;
   logic          RD_EN;
   logic [XW-1:0] RD_COL;
   logic [RW-1:0] RD_ROW;
   logic [PW-1:0] RD_TOP;
   logic [PW-1:0] RD_BOT;
   logic          RD_VALID;
   logic          FRAME_END;
   logic          FRAME_SWAP;
   logic          SYNC_ERR;

   modport master (
      output PIX_DATA, PIX_VALID, PIX_SOF, RD_EN, RD_COL, RD_ROW, FRAME_END,
      input  PIX_READY, RD_TOP, RD_BOT, RD_VALID, FRAME_SWAP, SYNC_ERR
   );

   modport slave (
      input  PIX_DATA, PIX_VALID, PIX_SOF, RD_EN, RD_COL, RD_ROW, FRAME_END,
      output PIX_READY, RD_TOP, RD_BOT, RD_VALID, FRAME_SWAP, SYNC_ERR
   );

endinterface

// File: rtl/led_dpram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
//  clk/rst : clock, async active-high reset (clears only the read register)
//  we/waddr/wdata : write port
//  re/raddr/rdata : read port, data one cycle after re, holds while re=0
module led_dpram #(
   parameter int AW = 6,
   parameter int DW = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered frame memory feeding a HUB75 led_driver.
//  CLK_I : system clock
//  RST_I : async reset, active-high
//  bus   : led_frame_buffer_if.slave
//          pixel stream in (valid/ready, SOF on pixel (0,0)) fills the back bank;
//          scan reads return top-half and bottom-half pixels of one column from
//          the front bank; banks exchange only on FRAME_END after a full frame.
// Two RAMs (TOP holds rows 0..HEIGHT/2-1, BOT the rest), each addressed as
// {bank, row, col}, so one access yields both halves the driver shifts out.
module led_frame_buffer
   import led_frame_buffer_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int HEIGHT = DEF_HEIGHT,
   parameter int BPC    = DEF_BPC
) (
   input  logic         CLK_I,
   input  logic         RST_I,
   led_frame_buffer_if.slave bus
);

   localparam int PW = CHANNELS * BPC;
   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);
   localparam int RW = YW - 1;
   localparam int AW = 1 + RW + XW;
   localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

   wr_state_t     state_q, state_d;
   logic [XW-1:0] wr_x_q, wr_x_d;
   logic [YW-1:0] wr_y_q, wr_y_d;
   logic          front_q, front_d;
   logic          swap_q, swap_d;
   logic          sync_err_q, sync_err_d;
   logic          live_q;
   logic          rd_valid_q;

   logic          ready;
   logic          accept;
   logic          we;
   logic [XW-1:0] w_col;
   logic [YW-1:0] w_y;

   logic [AW-1:0] waddr;
   logic [AW-1:0] raddr;
   logic [PW-1:0] top_data;
   logic [PW-1:0] bot_data;

   // live_q keeps READY low for the first cycle after reset release.
   assign ready  = live_q && (state_q != PEND_SWAP);
   assign accept = bus.PIX_VALID && ready;

   always_comb begin
      state_d    = state_q;
      wr_x_d     = wr_x_q;
      wr_y_d     = wr_y_q;
      front_d    = front_q;
      swap_d     = 1'b0;
      sync_err_d = sync_err_q;
      we         = 1'b0;
      w_col      = wr_x_q;
      w_y        = wr_y_q;

      case (state_q)
         WAIT_SOF: begin
            // Beats before the first SOF are taken and dropped.
            if (accept && bus.PIX_SOF) begin
               we      = 1'b1;
               w_col   = '0;
               w_y     = '0;
               wr_x_d  = XW'(1);
               wr_y_d  = '0;
               state_d = FILL;
            end
         end
         FILL: begin
            if (accept) begin
               we = 1'b1;
               if (bus.PIX_SOF) begin
                  // Source restarted its frame: resync onto the new SOF.
                  sync_err_d = 1'b1;
                  w_col      = '0;
                  w_y        = '0;
                  wr_x_d     = XW'(1);
                  wr_y_d     = '0;
               end else if (wr_x_q == X_LAST) begin
                  wr_x_d = '0;
                  wr_y_d = wr_y_q + 1'b1;
                  if (wr_y_q == Y_LAST) state_d = PEND_SWAP;
               end else begin
                  wr_x_d = wr_x_q + 1'b1;
               end
            end
         end
         PEND_SWAP: begin
            // FRAME_END is only honoured once the whole back frame is in.
            if (bus.FRAME_END) begin
               front_d = ~front_q;
               swap_d  = 1'b1;
               state_d = WAIT_SOF;
            end
         end
         default: state_d = WAIT_SOF;
      endcase
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q    <= WAIT_SOF;
         wr_x_q     <= '0;
         wr_y_q     <= '0;
         front_q    <= 1'b0;
         swap_q     <= 1'b0;
         sync_err_q <= 1'b0;
         live_q     <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_x_q     <= wr_x_d;
         wr_y_q     <= wr_y_d;
         front_q    <= front_d;
         swap_q     <= swap_d;
         sync_err_q <= sync_err_d;
         live_q     <= 1'b1;
         rd_valid_q <= bus.RD_EN;
      end
   end

   // Writes go to the back bank, reads to the front bank, so they never collide.
   // A read issued on the toggle edge still sees the old front (front_q pre-edge).
   assign waddr = {~front_q, w_y[RW-1:0], w_col};
   assign raddr = {front_q, bus.RD_ROW, bus.RD_COL};

   led_dpram #(.AW(AW), .DW(PW)) u_top_ram (
      .clk   (CLK_I),
      .rst   (RST_I),
      .we    (we && !w_y[YW-1]),
      .waddr (waddr),
      .wdata (bus.PIX_DATA),
      .re    (bus.RD_EN),
      .raddr (raddr),
      .rdata (top_data)
   );

   led_dpram #(.AW(AW), .DW(PW)) u_bot_ram (
      .clk   (CLK_I),
      .rst   (RST_I),
      .we    (we && w_y[YW-1]),
      .waddr (waddr),
      .wdata (bus.PIX_DATA),
      .re    (bus.RD_EN),
      .raddr (raddr),
      .rdata (bot_data)
   );

   assign bus.PIX_READY  = ready;
   assign bus.RD_TOP     = top_data;
   assign bus.RD_BOT     = bot_data;
   assign bus.RD_VALID   = rd_valid_q;
   assign bus.FRAME_SWAP = swap_q;
   assign bus.SYNC_ERR   = sync_err_q;

endmodule
